// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: request/response records,
// the illegal-read fill word and the address legality helper.
package dmem_ctrl_pkg;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [3:0]  byte_en;
        logic [31:0] write_data;
        logic [31:0] addr;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic        valid;
        logic [31:0] read_data;
        logic        yumi;
    } mem_out_s;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    // An address is illegal when it is not word aligned or lies above the bank
    function automatic logic addr_illegal(input logic [31:0] addr, input int aw);
        logic [31:0] hi_s;
        hi_s = addr >> (aw + 2);
        return (addr[1:0] != 2'b00) || (hi_s != 32'h0000_0000);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port 32-bit word store with per-byte write enables and a registered read.
// The array itself is never reset; only the read register is.
module dmem_bank #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    we,
    input  logic [3:0]              byte_en,
    input  logic [addr_width_p-1:0] addr,
    input  logic [31:0]             write_data,
    output logic [31:0]             read_data
);

    localparam int depth_lp = 1 << addr_width_p;

    logic [31:0] mem_r [depth_lp];

    // Byte-masked write into the array
    always_ff @(posedge clk) begin
        if (en && we) begin
            if (byte_en[0]) mem_r[addr][7:0]   <= write_data[7:0];
            if (byte_en[1]) mem_r[addr][15:8]  <= write_data[15:8];
            if (byte_en[2]) mem_r[addr][23:16] <= write_data[23:16];
            if (byte_en[3]) mem_r[addr][31:24] <= write_data[31:24];
        end
    end

    // Registered read; the word is held until the next read strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= 32'h0000_0000;
        end else if (en && !we) begin
            read_data <= mem_r[addr];
        end else begin
            read_data <= read_data;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one request at a time, sequences the read
// latency, flags illegal accesses and holds the response until the core consumes it.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int rd_lat_p     = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$bits(mem_in_s)-1:0]  to_mem_flat_i,
    output logic [$bits(mem_out_s)-1:0] from_mem_flat_o,
    output logic                        err_o,
    output logic                        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] lat_m1_lp = 2'(rd_lat_p - 1);

    state_t                  state_r;
    logic [1:0]              cnt_r;
    logic                    valid_r;
    logic [31:0]             read_data_r;
    logic                    err_r;
    logic                    busy_r;
    logic                    bad_rd_r;

    mem_in_s                 to_mem_s;
    mem_out_s                from_mem_s;
    logic                    accept_s;
    logic                    illegal_s;
    logic                    bank_en_s;
    logic                    bank_we_s;
    logic [addr_width_p-1:0] idx_s;
    logic [31:0]             bank_rdata_s;

    // Request decode: acceptance, legality and bank strobes
    always_comb begin
        to_mem_s  = mem_in_s'(to_mem_flat_i);
        accept_s  = (state_r == IDLE) && to_mem_s.valid;
        illegal_s = addr_illegal(to_mem_s.addr, addr_width_p);
        idx_s     = to_mem_s.addr[addr_width_p+1:2];
        bank_we_s = to_mem_s.wen;
        bank_en_s = accept_s && !(to_mem_s.wen && illegal_s);
    end

    dmem_bank #(
        .addr_width_p (addr_width_p)
    ) u_bank (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (bank_en_s),
        .we         (bank_we_s),
        .byte_en    (to_mem_s.byte_en),
        .addr       (idx_s),
        .write_data (to_mem_s.write_data),
        .read_data  (bank_rdata_s)
    );

    // Request/latency/response sequencer; valid rises one edge after RESP is entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            valid_r     <= 1'b0;
            read_data_r <= 32'h0000_0000;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            bad_rd_r    <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        err_r <= illegal_s;
                        if (to_mem_s.wen) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            bad_rd_r <= illegal_s;
                            cnt_r    <= lat_m1_lp;
                            busy_r   <= 1'b1;
                            state_r  <= (rd_lat_p == 1) ? RESP : WAIT;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_r <= 2'd1) begin
                        cnt_r   <= 2'd0;
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    if (!valid_r) begin
                        valid_r     <= 1'b1;
                        read_data_r <= bad_rd_r ? DEAD_BEEF : bank_rdata_s;
                    end else if (to_mem_s.yumi) begin
                        valid_r  <= 1'b0;
                        bad_rd_r <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 2'd0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Response packing; request acceptance is combinational from the registered state
    always_comb begin
        from_mem_s           = '0;
        from_mem_s.valid     = valid_r;
        from_mem_s.read_data = read_data_r;
        from_mem_s.yumi      = accept_s;
    end

    assign from_mem_flat_o = from_mem_s;
    assign err_o           = err_r;
    assign busy_o          = busy_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: three instances (read latency 1, 2, 4),
// a directed vector table, multi-cycle corner sequences and a random scoreboard run.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] addr;
        int          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    logic                        clk = 1'b0;
    logic                        reset_n = 1'b0;
    mem_in_s                     req [3];
    logic [$bits(mem_out_s)-1:0] rsp_flat [3];
    logic                        err_s [3];
    logic                        busy_s [3];

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] sb_q [$];
    logic [31:0] mdl [3][16];
    int          lat_of [3] = '{1, 2, 4};

    always #5 clk = ~clk;

    dmem_ctrl #(.addr_width_p(10), .rd_lat_p(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .to_mem_flat_i(req[0]),
        .from_mem_flat_o(rsp_flat[0]), .err_o(err_s[0]), .busy_o(busy_s[0]));
    dmem_ctrl #(.addr_width_p(10), .rd_lat_p(2)) u_dut_l2 (
        .clk(clk), .reset_n(reset_n), .to_mem_flat_i(req[1]),
        .from_mem_flat_o(rsp_flat[1]), .err_o(err_s[1]), .busy_o(busy_s[1]));
    dmem_ctrl #(.addr_width_p(10), .rd_lat_p(4)) u_dut_l4 (
        .clk(clk), .reset_n(reset_n), .to_mem_flat_i(req[2]),
        .from_mem_flat_o(rsp_flat[2]), .err_o(err_s[2]), .busy_o(busy_s[2]));

    function automatic mem_out_s rsp(input int k);
        return mem_out_s'(rsp_flat[k]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Starts at posedge+1; returns at the negedge following the accept edge
    task automatic do_req(input int k, input logic wen, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] addr, output int waited);
        req[k].valid = 1'b1; req[k].wen = wen; req[k].byte_en = be;
        req[k].write_data = wd; req[k].addr = addr;
        waited = 0;
        @(negedge clk);
        while (!rsp(k).yumi && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("accept_u%0d", k), 32'(rsp(k).yumi), 32'd1);
        @(posedge clk); #1;
        req[k].valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_done(input int k, output int errs);
        errs = 32'(err_s[k]);
        @(negedge clk);
        errs += 32'(err_s[k]);
        @(posedge clk); #1;
    endtask

    // Counts edges from the accept edge until valid; returns at the negedge valid is seen
    task automatic wait_rsp(input int k, output int lat, output int errs, output logic [31:0] rd);
        lat = 0; errs = 0;
        while (!rsp(k).valid && lat < 20) begin
            errs += 32'(err_s[k]);
            @(negedge clk);
            lat++;
        end
        errs += 32'(err_s[k]);
        check($sformatf("rsp_valid_u%0d", k), 32'(rsp(k).valid), 32'd1);
        rd = rsp(k).read_data;
    endtask

    task automatic sb_compare(input string name, input logic [31:0] rd);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check(name, rd, exp);
        end
    endtask

    task automatic consume(input int k, input int d);
        repeat (d) @(posedge clk);
        @(posedge clk); #1;
        req[k].yumi = 1'b1;
        @(posedge clk); #1;
        req[k].yumi = 1'b0;
    endtask

    task automatic read_check(input int k, input logic [31:0] addr, input logic [31:0] exp,
                              input int exp_err, input string name);
        int waited, lat, errs;
        logic [31:0] rd;
        do_req(k, 1'b0, 4'h0, 32'h0, addr, waited);
        sb_q.push_back(exp);
        wait_rsp(k, lat, errs, rd);
        check({name, "_lat"}, lat, lat_of[k]);
        check({name, "_err"}, errs, exp_err);
        sb_compare({name, "_data"}, rd);
        consume(k, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [12];
        int          waited, lat, errs;
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 4'hF, 32'hA5A5_1234, 32'h0000_0010, 0, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0010, 0, 32'hA5A5_1234};
        vecs[2]  = '{1'b1, 4'hF, 32'h1122_3344, 32'h0000_0020, 0, 32'h0};
        vecs[3]  = '{1'b1, 4'h5, 32'hFFFF_FFFF, 32'h0000_0020, 0, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0020, 0, 32'h11FF_33FF};
        vecs[5]  = '{1'b1, 4'hF, 32'hCAFE_F00D, 32'h0000_0024, 0, 32'h0};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0024, 0, 32'h0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0024, 0, 32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0002, 1, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 4'h0, 32'h0,         32'h0001_0000, 1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b1, 4'hF, 32'h0000_0000, 32'h0000_0011, 1, 32'h0};
        vecs[11] = '{1'b0, 4'h0, 32'h0,         32'h0000_0010, 0, 32'hA5A5_1234};

        for (int k = 0; k < 3; k++) req[k] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rsp(1).valid), 32'd0);
        check("rst_rdata", rsp(1).read_data, 32'h0);
        check("rst_busy", 32'(busy_s[1]), 32'd0);
        check("rst_err", 32'(err_s[1]), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Directed vector table on the latency-2 instance
        for (int i = 0; i < 12; i++) begin
            do_req(1, vecs[i].wen, vecs[i].be, vecs[i].data, vecs[i].addr, waited);
            if (i == 0) check("first_accept_after_reset", waited, 0);
            if (vecs[i].wen) begin
                check($sformatf("vec%0d_busy", i), 32'(busy_s[1]), 32'd0);
                write_done(1, errs);
                check($sformatf("vec%0d_err", i), errs, vecs[i].exp_err);
            end else begin
                check($sformatf("vec%0d_busy", i), 32'(busy_s[1]), 32'd1);
                sb_q.push_back(vecs[i].exp_rd);
                wait_rsp(1, lat, errs, rd);
                check($sformatf("vec%0d_lat", i), lat, 2);
                check($sformatf("vec%0d_err", i), errs, vecs[i].exp_err);
                sb_compare($sformatf("vec%0d_data", i), rd);
                consume(1, 0);
                @(negedge clk);
                check($sformatf("vec%0d_valid_drop", i), 32'(rsp(1).valid), 32'd0);
                @(posedge clk); #1;
            end
        end

        // Backpressure: response held for 5 cycles while a new request waits
        do_req(1, 1'b0, 4'h0, 32'h0, 32'h0000_0010, waited);
        sb_q.push_back(32'hA5A5_1234);
        wait_rsp(1, lat, errs, rd);
        sb_compare("bp_first_data", rd);
        req[1].valid = 1'b1; req[1].wen = 1'b0; req[1].addr = 32'h0000_0020;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid_c%0d", c), 32'(rsp(1).valid), 32'd1);
            check($sformatf("bp_data_c%0d", c), rsp(1).read_data, 32'hA5A5_1234);
            check($sformatf("bp_noacc_c%0d", c), 32'(rsp(1).yumi), 32'd0);
        end
        req[1].yumi = 1'b1;
        #1;
        check("bp_noacc_consume_cycle", 32'(rsp(1).yumi), 32'd0);
        @(posedge clk); #1;
        req[1].yumi = 1'b0;
        @(negedge clk);
        check("bp_accept_next_cycle", 32'(rsp(1).yumi), 32'd1);
        sb_q.push_back(32'h11FF_33FF);
        @(posedge clk); #1;
        req[1].valid = 1'b0;
        @(negedge clk);
        wait_rsp(1, lat, errs, rd);
        check("bp_second_lat", lat, 2);
        sb_compare("bp_second_data", rd);
        consume(1, 0);

        // Reset while the read is in WAIT
        do_req(1, 1'b0, 4'h0, 32'h0, 32'h0000_0010, waited);
        check("mid_busy_before", 32'(busy_s[1]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_busy_async", 32'(busy_s[1]), 32'd0);
        check("mid_valid_async", 32'(rsp(1).valid), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        do_req(1, 1'b1, 4'hF, 32'h1234_5678, 32'h0000_0030, waited);
        check("mid_first_accept", waited, 0);
        write_done(1, errs);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("mid_no_rsp_c%0d", c), 32'(rsp(1).valid), 32'd0);
        end
        @(posedge clk); #1;
        read_check(1, 32'h0000_0010, 32'hA5A5_1234, 0, "mid_mem_kept");
        read_check(1, 32'h0000_0030, 32'h1234_5678, 0, "mid_new_write");

        // Latency 1 and 4, then random back-to-back traffic against a byte-lane model
        for (int s = 0; s < 2; s++) begin
            int k;
            k = (s == 0) ? 0 : 2;
            do_req(k, 1'b1, 4'hF, 32'h0BAD_CAFE, 32'h0000_0040, waited);
            write_done(k, errs);
            read_check(k, 32'h0000_0040, 32'h0BAD_CAFE, 0, $sformatf("sweep_u%0d", k));
            for (int w = 0; w < 16; w++) begin
                logic [31:0] d;
                d = $urandom;
                do_req(k, 1'b1, 4'hF, d, 32'(w) << 2, waited);
                write_done(k, errs);
                mdl[k][w] = d;
            end
            for (int n = 0; n < 100; n++) begin
                logic        wen, bad;
                logic [3:0]  idx, be;
                logic [31:0] d, addr;
                wen  = 1'($urandom_range(0, 1));
                idx  = 4'($urandom_range(0, 15));
                be   = 4'($urandom_range(0, 15));
                d    = $urandom;
                bad  = ($urandom_range(0, 7) == 0);
                addr = {26'd0, idx, 2'b00};
                if (bad) begin
                    if ($urandom_range(0, 1) == 0) addr[0] = 1'b1;
                    else addr[20] = 1'b1;
                end
                do_req(k, wen, be, d, addr, waited);
                if (wen) begin
                    write_done(k, errs);
                    check($sformatf("rnd_u%0d_n%0d_werr", k, n), errs, 32'(bad));
                    if (!bad) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
                    end
                end else begin
                    sb_q.push_back(bad ? 32'hDEAD_BEEF : mdl[k][idx]);
                    wait_rsp(k, lat, errs, rd);
                    check($sformatf("rnd_u%0d_n%0d_lat", k, n), lat, lat_of[k]);
                    check($sformatf("rnd_u%0d_n%0d_rerr", k, n), errs, 32'(bad));
                    sb_compare($sformatf("rnd_u%0d_n%0d_data", k, n), rd);
                    consume(k, $urandom_range(0, 2));
                end
            end
        end

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter addr_width_p, default 10, which sets the word-address width (the memory depth is 2^addr_width_p words of 32 bits).
REQ-002 The block SHALL have parameter rd_lat_p, default 2, legal range 1..4, which sets the read latency in cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port to_mem_flat_i, input, $bits(mem_in_s): the core request, with fields valid, wen, byte_en[3:0], write_data[31:0], addr[31:0] and yumi (the core consumes the response).
REQ-006 The block SHALL have port from_mem_flat_o, output, $bits(mem_out_s): the response, with fields valid, read_data[31:0] and yumi (the controller accepts the request).
REQ-007 The block SHALL have port err_o, output, 1 bit: a one-cycle pulse on an illegal access.
REQ-008 The block SHALL have port busy_o, output, 1 bit: high whenever state != IDLE.

Function
REQ-009 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-010 from_mem.yumi SHALL equal (state==IDLE & to_mem.valid), combinationally; no request is accepted outside IDLE.
REQ-011 An accepted write SHALL update only the byte lanes enabled by byte_en at that clock edge, produce no response, and leave the FSM in IDLE.
REQ-012 An accepted read SHALL capture the word index and load the latency counter with rd_lat_p-1.
 - If rd_lat_p==1, the FSM goes to RESP.
 - Otherwise the FSM goes to WAIT.
REQ-013 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL enter RESP on the cycle the counter reaches 0.
REQ-014 Timing: the read is accepted at edge N, and from_mem.valid first goes high after edge N+rd_lat_p.
REQ-015 In RESP, valid=1 and read_data SHALL hold stable until the cycle in which to_mem.yumi=1; at that edge the FSM returns to IDLE.
REQ-016 to_mem.yumi SHALL be ignored outside RESP.
REQ-017 A request asserted in the same cycle as a response yumi SHALL NOT be accepted; it is accepted in the following cycle (IDLE).
REQ-018 Word index SHALL be addr[addr_width_p+1:2].
REQ-019 An access SHALL be illegal when addr[1:0]!=0 or when addr[31:addr_width_p+2]!=0.
REQ-020 An illegal access SHALL still be accepted (yumi=1) and SHALL pulse err_o for one cycle after the accept edge.
 - An illegal write is dropped.
 - An illegal read completes with normal timing, returning 32'hDEAD_BEEF.
REQ-021 A read SHALL return the memory contents as of the accept edge; a write in the same edge cannot occur because there is a single outstanding request.
REQ-022 byte_en==0 on a write SHALL be legal: it is accepted and performs no update.
REQ-023 Output fields not listed as driven SHALL be 0.

Reset
REQ-024 On reset_n low, the block SHALL asynchronously force: state=IDLE, counter=0, from_mem.valid=0, read_data=0, err_o=0, busy_o=0.
REQ-025 A reset asserted in WAIT or RESP SHALL abandon the pending read with no response after release.
REQ-026 Memory array contents SHALL NOT be reset.
REQ-027 The first request SHALL be accepted in the first cycle after reset_n deasserts.

Structure
REQ-028 mem_in_s, mem_out_s and the DEAD_BEEF constant SHALL live in the shared definitions package.
REQ-029 The FSM state enum SHALL be local to the block.
REQ-030 The storage SHALL be a sub-module dmem_bank: a 2^addr_width_p x 32 single-port array with a byte-write-enable write port and a registered read.
REQ-031 Latency sequencing and error checking SHALL stay in dmem_ctrl.
REQ-032 Implementation size SHALL be 150-300 lines total.

Verification
REQ-033 Write then read: write addr 0x10, data 0xA5A5_1234, byte_en 4'hF; read 0x10 with rd_lat_p=2 -> valid rises exactly 2 cycles after the read yumi, read_data=0xA5A5_1234.
REQ-034 Byte lanes: preload 0x1122_3344, write 0xFFFF_FFFF with byte_en 4'b0101 -> read returns 0x11FF_33FF.
REQ-035 Backpressure: hold to_mem.yumi low for 5 cycles in RESP -> valid and data stable for all 5 cycles; a new request presented meanwhile gets no yumi until the cycle after consumption.
REQ-036 Illegal access: read addr 0x0000_0002 and then 0x0001_0000 -> err_o pulses once per request, read_data=0xDEAD_BEEF.
REQ-037 Reset mid-read: assert reset_n low in WAIT -> valid stays 0 after release, busy_o=0, and the next write is accepted in the first cycle.
REQ-038 Parameter sweep: rd_lat_p in {1,4} -> latency 1 and 4 cycles; 100 random back-to-back requests match a scoreboard.
